// File: rtl/gfx_pkg.sv
// Shared graphics definitions: palette arbiter in-flight states and palette RAM geometry.
package gfx_pkg;

    localparam int PAL_WORD_AW = 8;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PE   = 2'd1,
        ARB_CPU  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// CPU starvation guard: counts consecutive cycles a pending CPU read loses to PE
// and raises force_cpu once the limit is reached.
module arb_starve_ctr #(
    parameter int MAX_CPU_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_req,
    input  logic pe_grant,
    input  logic cpu_grant,
    output logic force_cpu
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CPU_WAIT);

    logic [3:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (cpu_grant || !cpu_req) begin
            wait_cnt <= 4'd0;
        end else if (pe_grant && (wait_cnt != MAX_CNT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_cpu = cpu_req && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/palette_arb.sv
// Palette RAM read arbiter between the pixel engine (priority) and the CPU (starvation-guarded).
// Optional macro PALETTE_ARB_STATS_EN adds the cpu_stall_cycles counter output.
module palette_arb
    import gfx_pkg::*;
#(
    parameter int MAX_CPU_WAIT = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pe_req,
    input  logic [31:0]            pe_addr,
    input  logic                   pe_is_obj,
    input  logic                   cpu_req,
    input  logic [31:0]            cpu_addr,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic                   ram_en,
    output logic [PAL_WORD_AW-1:0] ram_addr,
    output logic [DATA_W-1:0]      pe_rdata,
    output logic                   pe_valid,
    output logic [DATA_W-1:0]      cpu_rdata,
`ifdef PALETTE_ARB_STATS_EN
    output logic [15:0]            cpu_stall_cycles,
`endif
    output logic                   cpu_valid
);

    logic              force_cpu;
    logic              pe_grant;
    logic              cpu_grant;
    arb_state_t        state_p1;
    logic [DATA_W-1:0] pe_last;
    logic [DATA_W-1:0] cpu_last;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{pe_addr[31:9], pe_addr[1:0], cpu_addr[31:10], cpu_addr[1:0]};

    arb_starve_ctr #(
        .MAX_CPU_WAIT(MAX_CPU_WAIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .pe_grant (pe_grant),
        .cpu_grant(cpu_grant),
        .force_cpu(force_cpu)
    );

    // Stage p0: same-cycle grant selection and RAM address
    always_comb begin
        pe_grant  = 1'b0;
        cpu_grant = 1'b0;
        if (!reset) begin
            if (force_cpu) begin
                cpu_grant = 1'b1;
            end else if (pe_req) begin
                pe_grant = 1'b1;
            end else if (cpu_req && (state_p1 != ARB_CPU)) begin
                cpu_grant = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        if (pe_grant) begin
            ram_addr = {pe_is_obj, pe_addr[8:2]};
        end else if (cpu_grant) begin
            ram_addr = cpu_addr[9:2];
        end
    end

    assign ram_en = pe_grant || cpu_grant;

    // Stage p1: read in flight, RAM data returns and is steered to its requester
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_p1 <= ARB_IDLE;
            pe_last  <= '0;
            cpu_last <= '0;
        end else begin
            if (pe_grant) begin
                state_p1 <= ARB_PE;
            end else if (cpu_grant) begin
                state_p1 <= ARB_CPU;
            end else begin
                state_p1 <= ARB_IDLE;
            end
            if (state_p1 == ARB_PE) begin
                pe_last <= ram_rdata;
            end
            if (state_p1 == ARB_CPU) begin
                cpu_last <= ram_rdata;
            end
        end
    end

    assign pe_valid  = (state_p1 == ARB_PE);
    assign cpu_valid = (state_p1 == ARB_CPU);
    assign pe_rdata  = pe_valid  ? ram_rdata : pe_last;
    assign cpu_rdata = cpu_valid ? ram_rdata : cpu_last;

`ifdef PALETTE_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_stall_cycles <= 16'd0;
        end else if (cpu_req && !cpu_grant && (cpu_stall_cycles != 16'hFFFF)) begin
            cpu_stall_cycles <= cpu_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_palette_arb.sv
// Scoreboard bench for palette_arb: stimulus pushes expected read data, a negedge monitor pops on valid.
module tb_palette_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pe_req = 1'b0;
    logic [31:0] pe_addr = 32'd0;
    logic        pe_is_obj = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] ram_rdata = 32'd0;
    logic        ram_en;
    logic [7:0]  ram_addr;
    logic [31:0] pe_rdata;
    logic        pe_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_valid;
`ifdef PALETTE_ARB_STATS_EN
    logic [15:0] cpu_stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] pe_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] pe_hold_exp = 32'd0;
    logic [31:0] cpu_hold_exp = 32'd0;

    palette_arb #(.MAX_CPU_WAIT(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .pe_req          (pe_req),
        .pe_addr         (pe_addr),
        .pe_is_obj       (pe_is_obj),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .ram_rdata       (ram_rdata),
        .ram_en          (ram_en),
        .ram_addr        (ram_addr),
        .pe_rdata        (pe_rdata),
        .pe_valid        (pe_valid),
        .cpu_rdata       (cpu_rdata),
`ifdef PALETTE_ARB_STATS_EN
        .cpu_stall_cycles(cpu_stall_cycles),
`endif
        .cpu_valid       (cpu_valid)
    );

    always #5 clock = ~clock;

    // Palette RAM model: word = {A5, addr, ~addr, addr}, one cycle after ram_en
    always @(posedge clock) begin
        if (ram_en) ram_rdata <= {8'hA5, ram_addr, ~ram_addr, ram_addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        logic [31:0] exp;
        if (reset) begin
            pe_hold_exp  = 32'd0;
            cpu_hold_exp = 32'd0;
        end else begin
            check("valid_exclusive", {31'd0, pe_valid & cpu_valid}, 32'd0);
            if (pe_valid) begin
                if (pe_q.size() == 0) begin
                    check("pe_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp = pe_q.pop_front();
                    check("pe_rdata", pe_rdata, exp);
                    pe_hold_exp = exp;
                end
            end else begin
                check("pe_hold", pe_rdata, pe_hold_exp);
            end
            if (cpu_valid) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, exp);
                    cpu_hold_exp = exp;
                end
            end else begin
                check("cpu_hold", cpu_rdata, cpu_hold_exp);
            end
        end
    end

    initial begin
        #1;
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_pe_valid", {31'd0, pe_valid}, 32'd0);
        check("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_pe_rdata", pe_rdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
`ifdef PALETTE_ARB_STATS_EN
        check("rst_stall", {16'd0, cpu_stall_cycles}, 32'd0);
`endif
        tick();
        tick();
        reset = 1'b0;

        // OBJ half PE read
        tick();
        pe_req = 1'b1; pe_is_obj = 1'b1; pe_addr = 32'h0000_0004;
        pe_q.push_back(32'hA5817E81);
        #1;
        check("pe_obj_ram_en", {31'd0, ram_en}, 32'd1);
        check("pe_obj_ram_addr", {24'd0, ram_addr}, 32'h81);
        tick();
        pe_req = 1'b0;

        // BG half PE read with junk upper/lower address bits
        tick();
        pe_req = 1'b1; pe_is_obj = 1'b0; pe_addr = 32'hFFFF_FE10;
        pe_q.push_back(32'hA504FB04);
        #1;
        check("pe_bg_ram_addr", {24'd0, ram_addr}, 32'h04);
        tick();
        pe_req = 1'b0;

        // Lone CPU read of the top palette word
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h0000_03FC;
        cpu_q.push_back(32'hA5FF00FF);
        #1;
        check("cpu_ram_en", {31'd0, ram_en}, 32'd1);
        check("cpu_ram_addr", {24'd0, ram_addr}, 32'hFF);
        tick();
        #1;
        check("cpu_inflight_no_regrant", {31'd0, ram_en}, 32'd0);
        tick();
        cpu_req = 1'b0;
        tick();

        // Simultaneous rise: PE first, then CPU once pe_req drops
        pe_req = 1'b1; pe_addr = 32'h10; pe_is_obj = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h008;
        pe_q.push_back(32'hA504FB04);
        #1;
        check("both_rise_pe_first", {24'd0, ram_addr}, 32'h04);
        tick();
        pe_req = 1'b0;
        cpu_q.push_back(32'hA502FD02);
        #1;
        check("both_rise_cpu_next", {24'd0, ram_addr}, 32'h02);
        tick();
        #1;
        check("both_rise_inflight", {31'd0, ram_en}, 32'd0);
        tick();
        cpu_req = 1'b0;
        tick();

        // Starvation: 8 PE grants then a forced CPU grant
        pe_req = 1'b1; pe_is_obj = 1'b1; pe_addr = 32'h0;
        cpu_req = 1'b1; cpu_addr = 32'h100;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            #1;
            if (i < 8) begin
                pe_q.push_back(32'hA5807F80);
                check("starve_pe_grant", {24'd0, ram_addr}, 32'h80);
            end else begin
                cpu_q.push_back(32'hA540BF40);
                check("force_cpu_grant", {24'd0, ram_addr}, 32'h40);
            end
        end
        tick();
        #1;
        check("no_pe_valid_after_force", {31'd0, pe_valid}, 32'd0);
        check("pe_regrant_after_force", {24'd0, ram_addr}, 32'h80);
        pe_q.push_back(32'hA5807F80);
        tick();
        pe_req = 1'b0; cpu_req = 1'b0;
        tick();

        // cpu_req drops while its read is in flight
        cpu_req = 1'b1; cpu_addr = 32'h3F0;
        cpu_q.push_back(32'hA5FC03FC);
        #1;
        check("cpu_drop_ram_addr", {24'd0, ram_addr}, 32'hFC);
        tick();
        cpu_req = 1'b0;
        #1;
        check("cpu_drop_no_new_read", {31'd0, ram_en}, 32'd0);
        tick();

        // Reset in the cycle after a CPU grant discards the read
        cpu_req = 1'b1; cpu_addr = 32'h044;
        #1;
        check("rst_mid_ram_addr", {24'd0, ram_addr}, 32'h11);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_cpu_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_mid_pe_valid", {31'd0, pe_valid}, 32'd0);
        check("rst_mid_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_mid_ram_addr0", {24'd0, ram_addr}, 32'd0);
        check("rst_mid_pe_rdata", pe_rdata, 32'd0);
        check("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
        tick();
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        check("rst_mid_no_late_valid", {31'd0, cpu_valid}, 32'd0);
        tick();

`ifdef PALETTE_ARB_STATS_EN
        // CPU starved by PE for 5 cycles
        pe_req = 1'b1; pe_is_obj = 1'b0; pe_addr = 32'h10;
        cpu_req = 1'b1; cpu_addr = 32'h008;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            pe_q.push_back(32'hA504FB04);
        end
        tick();
        pe_req = 1'b0; cpu_req = 1'b0;
        #1;
        check("stall_cycles", {16'd0, cpu_stall_cycles}, 32'd5);
        tick();
`endif

        tick();
        tick();
        check("pe_queue_drained", pe_q.size(), 32'd0);
        check("cpu_queue_drained", cpu_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
